seq_dispenser: RTL

//  Consumer end of the restricted-move sequence generator. Accepts packed 8-bit sequences (four 2-bit

---
 rtl/seq_pkg.sv | 31 +++
 rtl/seq_perm_check.sv | 9 +
 rtl/seq_dispenser.sv | 110 +++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared sequence types and helpers for the sequence generator and dispenser
package seq_pkg;
  localparam int SYM_W = 2;
  localparam int N_SYM = 4;
  localparam int SEQ_W = 8;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [SEQ_W-1:0] seq_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PART,
    OCC_FULL
  } occ_t;

  // Field 0 is the first symbol dispensed and sits in the top bits.
  function automatic sym_t seq_field(input seq_t s, input logic [1:0] idx);
    seq_t t;
    t = s >> {~idx, 1'b0};
    return t[SYM_W-1:0];
  endfunction

  function automatic logic seq_is_perm(input seq_t s);
    logic [N_SYM-1:0] seen;
    seen = '0;
    for (int i = 0; i < N_SYM; i++) begin
      seen[seq_field(s, 2'(i))] = 1'b1;
    end
    return &seen;
  endfunction
endpackage

// File: rtl/seq_perm_check.sv
// rtl/seq_perm_check.sv - combinational check that a packed sequence is a permutation of 0..3
module seq_perm_check
  import seq_pkg::*;
(
  input  logic [SEQ_W-1:0] seq,
  output logic             perm_ok
);
  assign perm_ok = seq_is_perm(seq);
endmodule

// File: rtl/seq_dispenser.sv
// rtl/seq_dispenser.sv - buffers checked sequences and dispenses one symbol per pop
module seq_dispenser
  import seq_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEQ_W-1:0] seq_in,
  input  logic             seq_valid,
  output logic             seq_ready,
  output logic [SYM_W-1:0] restricted,
  input  logic             pop,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic [SYM_W-1:0] peek_sym,
  output logic             peek_valid,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int CW = $clog2(DEPTH + 1);

  seq_t          slots   [DEPTH];
  seq_t          shifted [DEPTH];
  logic [CW-1:0] count_q;
  logic [1:0]    idx_q;
  occ_t          state_q, state_d;

  logic          perm_ok;
  logic          do_pop, last_pop;
  logic          accept, acc_ok, acc_bad;
  logic [CW-1:0] wr_idx;

  seq_perm_check u_check (
    .seq     (seq_in),
    .perm_ok (perm_ok)
  );

  assign sym_valid = (state_q != OCC_EMPTY);
  assign do_pop    = pop && sym_valid;
  assign last_pop  = do_pop && (idx_q == 2'd3);
  // A final pop frees slot 0 this cycle, so a full buffer can still take a sequence.
  assign seq_ready = (state_q != OCC_FULL) || last_pop;
  assign accept    = seq_valid && seq_ready;
  assign acc_ok    = accept && perm_ok;
  assign acc_bad   = accept && !perm_ok;
  assign wr_idx    = last_pop ? (count_q - CW'(1)) : count_q;

  assign sym_out    = seq_field(slots[0], idx_q);
  assign peek_sym   = (idx_q == 2'd3) ? seq_field(slots[1], 2'd0)
                                      : seq_field(slots[0], idx_q + 2'd1);
  assign peek_valid = (idx_q == 2'd3) ? (count_q >= CW'(2)) : sym_valid;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = slots[i+1];
    end
    shifted[DEPTH-1] = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OCC_EMPTY: if (acc_ok) state_d = OCC_PART;
      OCC_PART: begin
        if (acc_ok && !last_pop && (count_q == CW'(DEPTH - 1))) state_d = OCC_FULL;
        else if (last_pop && !acc_ok && (count_q == CW'(1))) state_d = OCC_EMPTY;
      end
      OCC_FULL: if (last_pop && !acc_ok) state_d = OCC_PART;
      default: state_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      idx_q      <= '0;
      restricted <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      case ({acc_ok, last_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (do_pop) idx_q <= idx_q + 2'd1;
      // New sequence lands at the tail, which moves down one when slot 0 retires.
      for (int i = 0; i < DEPTH; i++) begin
        if (acc_ok && (wr_idx == CW'(i))) slots[i] <= seq_in;
        else if (last_pop) slots[i] <= shifted[i];
      end
      if (acc_ok) restricted <= seq_in[SYM_W-1:0];
      err_pulse <= acc_bad;
      if (acc_bad && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
    end
  end
endmodule
